// File: rtl/rename_map_table_pkg.sv
// Shared rename-stage types and constants: tag encoding, widths and map types.
package rename_pkg;

  localparam int N_WAY     = 2;
  localparam int N_ROB     = 32;
  localparam int NUM_ARCH  = 32;
  localparam int ARCH_BITS = 5;
  localparam int PR_BITS   = $clog2(N_ROB + 32) + 1;
  localparam int DN_BITS   = $clog2(N_WAY) + 1;

  typedef logic [PR_BITS-1:0]   pr_tag_t;
  typedef logic [ARCH_BITS-1:0] arch_idx_t;
  typedef pr_tag_t [31:0]       map_t;

  localparam pr_tag_t NO_TAG      = pr_tag_t'(0);
  localparam pr_tag_t ZERO_REG_PR = pr_tag_t'(1);

  // Identity mapping used at reset: architectural r lives in physical r+1.
  function automatic pr_tag_t reset_tag(arch_idx_t r);
    return pr_tag_t'(r) + pr_tag_t'(1);
  endfunction

endpackage

// File: rtl/rename_map_table_if.sv
// Dispatch/retire/recovery bundle between the dispatch stage and the rename map table.
interface rename_map_table_if;
  import rename_pkg::*;

  logic [DN_BITS-1:0]         dispatch_num;
  logic [N_WAY-1:0]           dest_valid;
  arch_idx_t [N_WAY-1:0]      dest_arch;
  arch_idx_t [N_WAY-1:0]      src1_arch;
  arch_idx_t [N_WAY-1:0]      src2_arch;
  pr_tag_t   [N_WAY-1:0]      free_list_out;
  logic [N_WAY-1:0]           dispatched;
  logic [N_WAY-1:0]           retire_valid;
  arch_idx_t [N_WAY-1:0]      retire_arch;
  pr_tag_t   [N_WAY-1:0]      retire_tag;
  logic                       branch_haz;
  pr_tag_t   [N_WAY-1:0]      src1_tag;
  pr_tag_t   [N_WAY-1:0]      src2_tag;
  pr_tag_t   [N_WAY-1:0]      told;
  logic [N_WAY-1:0]           tag_used;
  map_t                       spec_map;
  map_t                       arch_map;

  modport master (
    output dispatch_num, dest_valid, dest_arch, src1_arch, src2_arch,
           free_list_out, dispatched, retire_valid, retire_arch, retire_tag,
           branch_haz,
    input  src1_tag, src2_tag, told, tag_used, spec_map, arch_map
  );

  modport slave (
    input  dispatch_num, dest_valid, dest_arch, src1_arch, src2_arch,
           free_list_out, dispatched, retire_valid, retire_arch, retire_tag,
           branch_haz,
    output src1_tag, src2_tag, told, tag_used, spec_map, arch_map
  );

endinterface

// File: rtl/rename_map_table_bypass.sv
// Single-lane lookup: forwards the tag of the nearest earlier live lane writing
// the same architectural register, else the map entry; x0 always resolves to x0's tag.
module map_bypass_lane
  import rename_pkg::*;
#(
  parameter int LANE = 0
) (
  input  arch_idx_t             arch_i,
  input  pr_tag_t               map_entry_i,
  input  arch_idx_t [N_WAY-1:0] lane_dest_i,
  input  pr_tag_t   [N_WAY-1:0] lane_tag_i,
  input  logic      [N_WAY-1:0] lane_live_i,
  output pr_tag_t               tag_o
);

  pr_tag_t fwd_s;

  // Scan earlier lanes in ascending order so the closest one overrides the rest.
  always_comb begin
    fwd_s = map_entry_i;
    for (int j = 0; j < N_WAY; j++) begin
      fwd_s = ((j < LANE) && lane_live_i[j] && (lane_dest_i[j] == arch_i))
              ? lane_tag_i[j] : fwd_s;
    end
    tag_o = (arch_i == ARCH_BITS'(0)) ? ZERO_REG_PR : fwd_s;
  end

endmodule

// File: rtl/rename_map_table.sv
// Rename map stage: speculative and architectural maps, intra-group bypass,
// and recovery of the speculative map from the architectural map on branch_haz.
module rename_map_table
  import rename_pkg::*;
(
  input logic              clock,
  input logic              reset,
  rename_map_table_if.slave bus
);

  map_t             spec_map_q, spec_map_d;
  map_t             arch_map_q, arch_map_d;
  logic [N_WAY-1:0] lane_valid_s;
  logic [N_WAY-1:0] lane_live_s;
  logic [N_WAY-1:0] tag_used_s;
  pr_tag_t          src1_fwd_s [N_WAY];
  pr_tag_t          src2_fwd_s [N_WAY];
  pr_tag_t          told_fwd_s [N_WAY];

  // Qualify lanes: in-group, and live when it writes a non-x0 destination.
  always_comb begin
    lane_valid_s = '0;
    lane_live_s  = '0;
    tag_used_s   = '0;
    for (int i = 0; i < N_WAY; i++) begin
      lane_valid_s[i] = (DN_BITS'(i) < bus.dispatch_num);
      lane_live_s[i]  = lane_valid_s[i] & bus.dest_valid[i] &
                        (bus.dest_arch[i] != ARCH_BITS'(0));
      tag_used_s[i]   = lane_live_s[i] & bus.dispatched[i];
    end
  end

  for (genvar g = 0; g < N_WAY; g++) begin : g_lane
    map_bypass_lane #(.LANE(g)) u_src1 (
      .arch_i      (bus.src1_arch[g]),
      .map_entry_i (spec_map_q[bus.src1_arch[g]]),
      .lane_dest_i (bus.dest_arch),
      .lane_tag_i  (bus.free_list_out),
      .lane_live_i (lane_live_s),
      .tag_o       (src1_fwd_s[g])
    );
    map_bypass_lane #(.LANE(g)) u_src2 (
      .arch_i      (bus.src2_arch[g]),
      .map_entry_i (spec_map_q[bus.src2_arch[g]]),
      .lane_dest_i (bus.dest_arch),
      .lane_tag_i  (bus.free_list_out),
      .lane_live_i (lane_live_s),
      .tag_o       (src2_fwd_s[g])
    );
    map_bypass_lane #(.LANE(g)) u_told (
      .arch_i      (bus.dest_arch[g]),
      .map_entry_i (spec_map_q[bus.dest_arch[g]]),
      .lane_dest_i (bus.dest_arch),
      .lane_tag_i  (bus.free_list_out),
      .lane_live_i (lane_live_s),
      .tag_o       (told_fwd_s[g])
    );
  end

  // Drive lane outputs; lanes outside the group read as zero, told only for live lanes.
  always_comb begin
    bus.src1_tag = '0;
    bus.src2_tag = '0;
    bus.told     = '0;
    bus.tag_used = tag_used_s;
    for (int i = 0; i < N_WAY; i++) begin
      bus.src1_tag[i] = lane_valid_s[i] ? src1_fwd_s[i] : NO_TAG;
      bus.src2_tag[i] = lane_valid_s[i] ? src2_fwd_s[i] : NO_TAG;
      bus.told[i]     = lane_live_s[i]  ? told_fwd_s[i] : NO_TAG;
    end
  end

  assign bus.spec_map = spec_map_q;
  assign bus.arch_map = arch_map_q;

  // Next-state maps: ascending lane order so the youngest writer of a register wins.
  always_comb begin
    spec_map_d = spec_map_q;
    arch_map_d = arch_map_q;
    for (int i = 0; i < N_WAY; i++) begin
      spec_map_d[bus.dest_arch[i]] = tag_used_s[i] ? bus.free_list_out[i]
                                                   : spec_map_d[bus.dest_arch[i]];
      arch_map_d[bus.retire_arch[i]] =
        (bus.retire_valid[i] && (bus.retire_arch[i] != ARCH_BITS'(0)))
        ? bus.retire_tag[i] : arch_map_d[bus.retire_arch[i]];
    end
  end

  // Map state: reset to identity; recovery copies the post-retire architectural map.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_ARCH; r++) begin
        spec_map_q[r] <= reset_tag(arch_idx_t'(r));
        arch_map_q[r] <= reset_tag(arch_idx_t'(r));
      end
    end else if (bus.branch_haz) begin
      spec_map_q <= arch_map_d;
      arch_map_q <= arch_map_d;
    end else begin
      spec_map_q <= spec_map_d;
      arch_map_q <= arch_map_d;
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed + randomized bench for rename_map_table against a behavioural rename model.
module tb_rename_map_table;

  logic clock;
  logic reset;
  int   tests  = 0;
  int   failed = 0;
  int   spec_m [32];
  int   arch_m [32];

  rename_map_table_if rif ();

  rename_map_table dut (
    .clock (clock),
    .reset (reset),
    .bus   (rif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_live(int j);
    return (j < int'(rif.dispatch_num)) && (rif.dest_valid[j] == 1'b1) &&
           (rif.dest_arch[j] != 5'd0);
  endfunction

  // Source/dest lookup as stated: nearest earlier live lane with that dest, else map.
  function automatic int m_lookup(int lane, int arch);
    if (arch == 0) return 1;
    for (int j = lane - 1; j >= 0; j--)
      if (m_live(j) && int'(rif.dest_arch[j]) == arch) return int'(rif.free_list_out[j]);
    return spec_m[arch];
  endfunction

  function automatic int pick_arch();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      spec_m[r] = r + 1;
      arch_m[r] = r + 1;
    end
  endtask

  task automatic clear_inputs();
    rif.dispatch_num  = '0;
    rif.dest_valid    = '0;
    rif.dest_arch     = '0;
    rif.src1_arch     = '0;
    rif.src2_arch     = '0;
    rif.free_list_out = '0;
    rif.dispatched    = '0;
    rif.retire_valid  = '0;
    rif.retire_arch   = '0;
    rif.retire_tag    = '0;
    rif.branch_haz    = 1'b0;
    reset             = 1'b0;
  endtask

  // Check all outputs against the model, clock once, then advance the model.
  task automatic step(input string tag);
    int nspec [32];
    int narch [32];
    #1;
    for (int i = 0; i < 2; i++) begin
      bit valid;
      valid = (i < int'(rif.dispatch_num));
      if (m_live(i)) begin
        assert (rif.free_list_out[i] != 7'd0) else begin
          failed++;
          $error("FAIL %s.free_tag_zero lane=%0d", tag, i);
        end
      end
      check($sformatf("%s.src1[%0d]", tag, i), 32'(rif.src1_tag[i]),
            valid ? 32'(m_lookup(i, int'(rif.src1_arch[i]))) : 32'd0);
      check($sformatf("%s.src2[%0d]", tag, i), 32'(rif.src2_tag[i]),
            valid ? 32'(m_lookup(i, int'(rif.src2_arch[i]))) : 32'd0);
      check($sformatf("%s.told[%0d]", tag, i), 32'(rif.told[i]),
            m_live(i) ? 32'(m_lookup(i, int'(rif.dest_arch[i]))) : 32'd0);
      check($sformatf("%s.used[%0d]", tag, i), 32'(rif.tag_used[i]),
            32'(m_live(i) && rif.dispatched[i]));
    end
    for (int r = 0; r < 32; r++) begin
      check($sformatf("%s.spec_map[%0d]", tag, r), 32'(rif.spec_map[r]), 32'(spec_m[r]));
      check($sformatf("%s.arch_map[%0d]", tag, r), 32'(rif.arch_map[r]), 32'(arch_m[r]));
    end
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        nspec[r] = r + 1;
        narch[r] = r + 1;
      end
    end else begin
      narch = arch_m;
      for (int i = 0; i < 2; i++)
        if (rif.retire_valid[i] && rif.retire_arch[i] != 5'd0)
          narch[int'(rif.retire_arch[i])] = int'(rif.retire_tag[i]);
      if (rif.branch_haz) nspec = narch;
      else begin
        nspec = spec_m;
        for (int i = 0; i < 2; i++)
          if (m_live(i) && rif.dispatched[i])
            nspec[int'(rif.dest_arch[i])] = int'(rif.free_list_out[i]);
      end
    end
    @(posedge clock);
    #1;
    spec_m = nspec;
    arch_m = narch;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    // Reset state and plain lookups
    rif.dispatch_num = 2'd2;
    rif.src1_arch[0] = 5'd3;
    rif.src1_arch[1] = 5'd5;
    #1;
    check("tp1.src1_0", 32'(rif.src1_tag[0]), 32'd4);
    check("tp1.src1_1", 32'(rif.src1_tag[1]), 32'd6);
    check("tp1.told", 32'(rif.told), 32'd0);
    check("tp1.used", 32'(rif.tag_used), 32'd0);
    check("tp1.spec31", 32'(rif.spec_map[31]), 32'd32);
    step("tp1");

    // Intra-group forwarding of x7
    clear_inputs();
    rif.dispatch_num     = 2'd2;
    rif.dest_valid       = 2'b11;
    rif.dest_arch[0]     = 5'd7;
    rif.free_list_out[0] = 7'd40;
    rif.src1_arch[1]     = 5'd7;
    rif.dest_arch[1]     = 5'd7;
    rif.free_list_out[1] = 7'd41;
    rif.dispatched       = 2'b11;
    #1;
    check("tp2.src1_1", 32'(rif.src1_tag[1]), 32'd40);
    check("tp2.told_0", 32'(rif.told[0]), 32'd8);
    check("tp2.told_1", 32'(rif.told[1]), 32'd40);
    step("tp2");
    check("tp2.spec7", 32'(rif.spec_map[7]), 32'd41);

    // Destination x0 is not live
    clear_inputs();
    rif.dispatch_num     = 2'd1;
    rif.dest_valid       = 2'b01;
    rif.free_list_out[0] = 7'd42;
    rif.dispatched       = 2'b01;
    #1;
    check("tp3.told", 32'(rif.told[0]), 32'd0);
    check("tp3.used", 32'(rif.tag_used), 32'd0);
    step("tp3");
    check("tp3.spec0", 32'(rif.spec_map[0]), 32'd1);

    // Recovery restores x9 to its retired mapping
    clear_inputs();
    rif.dispatch_num = 2'd1; rif.dest_valid = 2'b01; rif.dest_arch[0] = 5'd9;
    rif.free_list_out[0] = 7'd50; rif.dispatched = 2'b01;
    step("tp4a");
    clear_inputs();
    rif.retire_valid = 2'b01; rif.retire_arch[0] = 5'd9; rif.retire_tag[0] = 7'd50;
    step("tp4b");
    clear_inputs();
    rif.dispatch_num = 2'd1; rif.dest_valid = 2'b01; rif.dest_arch[0] = 5'd9;
    rif.free_list_out[0] = 7'd51; rif.dispatched = 2'b01;
    step("tp4c");
    check("tp4.spec9_spec", 32'(rif.spec_map[9]), 32'd51);
    clear_inputs();
    rif.branch_haz = 1'b1;
    step("tp4d");
    check("tp4.spec9_rec", 32'(rif.spec_map[9]), 32'd50);
    clear_inputs();
    rif.dispatch_num = 2'd1; rif.src1_arch[0] = 5'd9;
    #1;
    check("tp4.src1_x9", 32'(rif.src1_tag[0]), 32'd50);
    step("tp4e");

    // Recovery with same-cycle retire and dispatch of x4
    clear_inputs();
    rif.branch_haz = 1'b1;
    rif.retire_valid = 2'b01; rif.retire_arch[0] = 5'd4; rif.retire_tag[0] = 7'd60;
    rif.dispatch_num = 2'd1; rif.dest_valid = 2'b01; rif.dest_arch[0] = 5'd4;
    rif.free_list_out[0] = 7'd61; rif.dispatched = 2'b01;
    step("tp5");
    check("tp5.spec4", 32'(rif.spec_map[4]), 32'd60);
    check("tp5.arch4", 32'(rif.arch_map[4]), 32'd60);

    // Reset discards a same-cycle dispatch
    clear_inputs();
    rif.dispatch_num = 2'd1; rif.dest_valid = 2'b01; rif.dest_arch[0] = 5'd2;
    rif.free_list_out[0] = 7'd44; rif.dispatched = 2'b01;
    step("tp6a");
    check("tp6.spec2_pre", 32'(rif.spec_map[2]), 32'd44);
    rif.free_list_out[0] = 7'd45;
    reset = 1'b1;
    step("tp6b");
    reset = 1'b0;
    check("tp6.spec2", 32'(rif.spec_map[2]), 32'd3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      rif.dispatch_num = 2'($urandom_range(0, 2));
      rif.dest_valid   = 2'($urandom_range(0, 3));
      rif.dispatched   = 2'($urandom_range(0, 3));
      rif.retire_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        rif.dest_arch[i]     = 5'(pick_arch());
        rif.src1_arch[i]     = 5'(pick_arch());
        rif.src2_arch[i]     = 5'(pick_arch());
        rif.free_list_out[i] = 7'($urandom_range(1, 127));
        rif.retire_arch[i]   = 5'(pick_arch());
        rif.retire_tag[i]    = 7'($urandom_range(1, 127));
      end
      rif.branch_haz = ($urandom_range(0, 15) == 0);
      reset          = ($urandom_range(0, 63) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
